// File: rtl/iram_pkg.sv
// Shared defaults, payload layout and ROB index helpers for the instruction payload RAM.
package iram_pkg;

  localparam int IRAM_LANES     = 2;
  localparam int IRAM_DEPTH     = 16;
  localparam int IRAM_PAYLOAD_W = 51;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  ins_type;
    logic        imm_flag;
    logic [31:0] immediate;
    logic [5:0]  dest;
  } payload_t;

  // The lane field sits in the low bits of the ROB index; lane_w is 0 for a single lane.
  function automatic int unsigned rob_lane(input int unsigned rob, input int unsigned lane_w);
    return rob & ((32'd1 << lane_w) - 32'd1);
  endfunction

  function automatic int unsigned rob_pack(input int unsigned rob, input int unsigned lane_w);
    return rob >> lane_w;
  endfunction

endpackage

// File: rtl/iram_mp_if.sv
// Dispatch-write / issue-read bus of the instruction payload RAM.
interface iram_mp_if #(
  parameter int LANES     = 2,
  parameter int DEPTH     = 16,
  parameter int PAYLOAD_W = 51,
  parameter int RPORTS    = 2
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int PACK_W = $clog2(DEPTH);
  localparam int ROB_W  = PACK_W + LANE_W;

  logic [LANES-1:0]           wr_valid_i;
  logic [PACK_W-1:0]          wr_pack_i;
  logic [LANES*PAYLOAD_W-1:0] wr_payload_i;
  logic                       release_i;
  logic [PACK_W-1:0]          release_pack_i;
  logic                       flush_i;
  logic [RPORTS-1:0]          rd_req_i;
  logic [RPORTS*ROB_W-1:0]    rd_rob_i;
  logic [RPORTS-1:0]          rd_valid_o;
  logic [RPORTS-1:0]          rd_miss_o;
  logic [RPORTS*PAYLOAD_W-1:0] rd_payload_o;

  modport master (
    output wr_valid_i, wr_pack_i, wr_payload_i, release_i, release_pack_i, flush_i,
           rd_req_i, rd_rob_i,
    input  rd_valid_o, rd_miss_o, rd_payload_o
  );

  modport slave (
    input  wr_valid_i, wr_pack_i, wr_payload_i, release_i, release_pack_i, flush_i,
           rd_req_i, rd_rob_i,
    output rd_valid_o, rd_miss_o, rd_payload_o
  );
endinterface

// File: rtl/iram_bank.sv
// One lane of payload storage: DEPTH entries, one write port, RPORTS combinational reads.
// Valid bits are reset/cleared by release and flush; payload storage is never reset.
module iram_bank #(
  parameter int DEPTH     = 16,
  parameter int PAYLOAD_W = 51,
  parameter int RPORTS    = 2,
  localparam int PACK_W   = $clog2(DEPTH)
) (
  input  logic                               cpu_clk_i,
  input  logic                               cpu_rst_i,
  input  logic                               wr_en,
  input  logic [PACK_W-1:0]                  wr_pack,
  input  logic [PAYLOAD_W-1:0]               wr_data,
  input  logic                               release_en,
  input  logic [PACK_W-1:0]                  release_pack,
  input  logic                               flush,
  input  logic [RPORTS-1:0][PACK_W-1:0]      rd_pack,
  output logic [RPORTS-1:0][PAYLOAD_W-1:0]   rd_data,
  output logic [RPORTS-1:0]                  rd_vld
);

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     vld;

  // Data is stored even during a flush; only the valid bit is suppressed.
  always_ff @(posedge cpu_clk_i) begin
    if (wr_en) begin
      mem[wr_pack] <= wr_data;
    end
  end

  // Write is applied after release so a same-pack write keeps its entry valid.
  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      vld <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (release_en) begin
        vld[release_pack] <= 1'b0;
      end
      if (wr_en) begin
        vld[wr_pack] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_vld  = '0;
    for (int p = 0; p < RPORTS; p++) begin
      rd_data[p] = mem[rd_pack[p]];
      rd_vld[p]  = vld[rd_pack[p]];
    end
  end

endmodule

// File: rtl/iram_mp.sv
// Multi-port instruction payload RAM: LANES banks, lane mux and registered read results.
// Optional same-cycle write-to-read bypass under `define IRAM_BYPASS_EN.
module iram_mp
  import iram_pkg::*;
#(
  parameter int LANES     = IRAM_LANES,
  parameter int DEPTH     = IRAM_DEPTH,
  parameter int PAYLOAD_W = IRAM_PAYLOAD_W,
  parameter int RPORTS    = 2
) (
  input  logic      cpu_clk_i,
  input  logic      cpu_rst_i,
  iram_mp_if.slave  bus
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int LSEL_W = (LANES > 1) ? LANE_W : 1;
  localparam int PACK_W = $clog2(DEPTH);
  localparam int ROB_W  = PACK_W + LANE_W;

  logic [LANES-1:0][RPORTS-1:0][PAYLOAD_W-1:0] bank_data;
  logic [LANES-1:0][RPORTS-1:0]                bank_vld;
  logic [RPORTS-1:0][PACK_W-1:0]               rd_pack;
  logic [RPORTS-1:0][LSEL_W-1:0]               rd_lane;
  logic [RPORTS-1:0]                           rd_hit;
  logic [RPORTS-1:0][PAYLOAD_W-1:0]            rd_data;
  logic [RPORTS-1:0][PAYLOAD_W-1:0]            payload_q;
  logic [RPORTS-1:0]                           valid_q;
  logic [RPORTS-1:0]                           miss_q;

  for (genvar l = 0; l < LANES; l++) begin : g_bank
    iram_bank #(
      .DEPTH     (DEPTH),
      .PAYLOAD_W (PAYLOAD_W),
      .RPORTS    (RPORTS)
    ) u_bank (
      .cpu_clk_i    (cpu_clk_i),
      .cpu_rst_i    (cpu_rst_i),
      .wr_en        (bus.wr_valid_i[l]),
      .wr_pack      (bus.wr_pack_i),
      .wr_data      (bus.wr_payload_i[l*PAYLOAD_W +: PAYLOAD_W]),
      .release_en   (bus.release_i),
      .release_pack (bus.release_pack_i),
      .flush        (bus.flush_i),
      .rd_pack      (rd_pack),
      .rd_data      (bank_data[l]),
      .rd_vld       (bank_vld[l])
    );
  end

  always_comb begin
    rd_pack = '0;
    rd_lane = '0;
    for (int p = 0; p < RPORTS; p++) begin
      rd_lane[p] = LSEL_W'(rob_lane(32'(bus.rd_rob_i[p*ROB_W +: ROB_W]), LANE_W));
      rd_pack[p] = PACK_W'(rob_pack(32'(bus.rd_rob_i[p*ROB_W +: ROB_W]), LANE_W));
    end
  end

`ifdef IRAM_BYPASS_EN
  logic [LANES-1:0][PAYLOAD_W-1:0] wr_lane_data;
  assign wr_lane_data = bus.wr_payload_i;
`endif

  // Storage reflects pre-edge state; the bypass then overrides with in-flight write data.
  always_comb begin
    rd_hit  = '0;
    rd_data = '0;
    for (int p = 0; p < RPORTS; p++) begin
      rd_hit[p]  = bank_vld[rd_lane[p]][p];
      rd_data[p] = bank_data[rd_lane[p]][p];
`ifdef IRAM_BYPASS_EN
      if (bus.wr_valid_i[rd_lane[p]] && (bus.wr_pack_i == rd_pack[p])) begin
        rd_hit[p]  = 1'b1;
        rd_data[p] = wr_lane_data[rd_lane[p]];
      end
`endif
    end
  end

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      valid_q   <= '0;
      miss_q    <= '0;
      payload_q <= '0;
    end else begin
      for (int p = 0; p < RPORTS; p++) begin
        valid_q[p] <= bus.rd_req_i[p];
        miss_q[p]  <= bus.rd_req_i[p] & ~rd_hit[p];
        if (bus.rd_req_i[p]) begin
          payload_q[p] <= rd_hit[p] ? rd_data[p] : '0;
        end
      end
    end
  end

  assign bus.rd_valid_o   = valid_q;
  assign bus.rd_miss_o    = miss_q;
  assign bus.rd_payload_o = payload_q;

endmodule

// File: tb/tb_iram_mp.sv
// Randomised and directed bench for iram_mp against an array-based reference model.
module tb_iram_mp;
  import iram_pkg::*;

  localparam int LANES = 2;
  localparam int DEPTH = 16;
  localparam int PW    = 51;
  localparam int RP    = 2;
  localparam int PKW   = 4;
  localparam int RW    = 5;

  logic cpu_clk_i = 1'b0;
  logic cpu_rst_i = 1'b1;
  always #5 cpu_clk_i = ~cpu_clk_i;

  iram_mp_if #(.LANES(LANES), .DEPTH(DEPTH), .PAYLOAD_W(PW), .RPORTS(RP)) bus ();

  iram_mp #(.LANES(LANES), .DEPTH(DEPTH), .PAYLOAD_W(PW), .RPORTS(RP)) dut (
    .cpu_clk_i (cpu_clk_i),
    .cpu_rst_i (cpu_rst_i),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus for the next edge.
  logic [LANES-1:0] wv;
  int               wpack;
  logic [PW-1:0]    wpay [LANES];
  logic             rel;
  int               relpack;
  logic             fl;
  logic [RP-1:0]    req;
  int               rob [RP];

  // Reference model: entry contents, validity and the expected registered outputs.
  logic [PW-1:0] mem_m [LANES][DEPTH];
  bit            vld_m [LANES][DEPTH];
  bit            ev [RP];
  bit            em [RP];
  logic [PW-1:0] ep [RP];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic idle();
    wv  = '0;
    wpack = 0;
    rel = 1'b0;
    relpack = 0;
    fl  = 1'b0;
    req = '0;
    for (int l = 0; l < LANES; l++) wpay[l] = '0;
    for (int p = 0; p < RP; p++) rob[p] = 0;
  endtask

  task automatic drive();
    bus.wr_valid_i     = wv;
    bus.wr_pack_i      = PKW'(wpack);
    for (int l = 0; l < LANES; l++) bus.wr_payload_i[l*PW +: PW] = wpay[l];
    bus.release_i      = rel;
    bus.release_pack_i = PKW'(relpack);
    bus.flush_i        = fl;
    bus.rd_req_i       = req;
    for (int p = 0; p < RP; p++) bus.rd_rob_i[p*RW +: RW] = RW'(rob[p]);
  endtask

  task automatic model_reset();
    for (int l = 0; l < LANES; l++)
      for (int d = 0; d < DEPTH; d++) vld_m[l][d] = 1'b0;
    for (int p = 0; p < RP; p++) begin
      ev[p] = 1'b0;
      em[p] = 1'b0;
      ep[p] = '0;
    end
  endtask

  // Predict, update the model, clock once, then compare every output.
  task automatic cycle();
    bit hit;
    logic [PW-1:0] d;
    int ln, pk;
    drive();
    for (int p = 0; p < RP; p++) begin
      if (req[p]) begin
        ln  = rob[p] % LANES;
        pk  = rob[p] / LANES;
        hit = vld_m[ln][pk];
        d   = mem_m[ln][pk];
`ifdef IRAM_BYPASS_EN
        if (wv[ln] && wpack == pk) begin
          hit = 1'b1;
          d   = wpay[ln];
        end
`endif
        ev[p] = 1'b1;
        em[p] = !hit;
        ep[p] = hit ? d : '0;
      end else begin
        ev[p] = 1'b0;
        em[p] = 1'b0;
      end
    end
    for (int l = 0; l < LANES; l++) if (wv[l]) mem_m[l][wpack] = wpay[l];
    if (fl) begin
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < DEPTH; k++) vld_m[l][k] = 1'b0;
    end else begin
      if (rel) for (int l = 0; l < LANES; l++) vld_m[l][relpack] = 1'b0;
      for (int l = 0; l < LANES; l++) if (wv[l]) vld_m[l][wpack] = 1'b1;
    end
    @(posedge cpu_clk_i);
    #1;
    for (int p = 0; p < RP; p++) begin
      chk("rd_valid", 64'(bus.rd_valid_o[p]), 64'(ev[p]));
      chk("rd_miss", 64'(bus.rd_miss_o[p]), 64'(em[p]));
      chk("rd_payload", 64'(bus.rd_payload_o[p*PW +: PW]), 64'(ep[p]));
    end
  endtask

  initial begin
    payload_t pl;
    for (int l = 0; l < LANES; l++)
      for (int k = 0; k < DEPTH; k++) mem_m[l][k] = '0;
    model_reset();
    idle();
    drive();
    repeat (2) @(posedge cpu_clk_i);
    #1;
    chk("reset_valid", 64'(bus.rd_valid_o), 64'h0);
    chk("reset_miss", 64'(bus.rd_miss_o), 64'h0);
    chk("reset_payload", 64'(bus.rd_payload_o[63:0]), 64'h0);
    cpu_rst_i = 1'b0;

    // 1: write pack 3 lanes 0/1, read rob 6/7 next cycle.
    idle(); wv = 2'b11; wpack = 3; wpay[0] = 51'h0A; wpay[1] = 51'h0B; cycle();
    idle(); req = 2'b11; rob[0] = 6; rob[1] = 7; cycle();
    chk("t1_valid", 64'(bus.rd_valid_o), 64'h3);
    chk("t1_miss", 64'(bus.rd_miss_o), 64'h0);
    chk("t1_pay0", 64'(bus.rd_payload_o[0 +: PW]), 64'h0A);
    chk("t1_pay1", 64'(bus.rd_payload_o[PW +: PW]), 64'h0B);

    // 2: never-written entry misses with zero payload.
    idle(); req = 2'b01; rob[0] = 9; cycle();
    chk("t2_valid", 64'(bus.rd_valid_o[0]), 64'h1);
    chk("t2_miss", 64'(bus.rd_miss_o[0]), 64'h1);
    chk("t2_pay", 64'(bus.rd_payload_o[0 +: PW]), 64'h0);

    // 3: read in the release cycle hits, next cycle misses.
    pl = '{opcode: 7'h13, ins_type: 5'h2, imm_flag: 1'b1, immediate: 32'hDEAD_BEEF, dest: 6'h21};
    idle(); wv = 2'b11; wpack = 5; wpay[0] = pl; wpay[1] = 51'h77; cycle();
    idle(); rel = 1'b1; relpack = 5; req = 2'b01; rob[0] = 10; cycle();
    chk("t3_hit_miss", 64'(bus.rd_miss_o[0]), 64'h0);
    chk("t3_hit_pay", 64'(bus.rd_payload_o[0 +: PW]), 64'(pl));
    idle(); req = 2'b01; rob[0] = 10; cycle();
    chk("t3_after_miss", 64'(bus.rd_miss_o[0]), 64'h1);

    // 4: same-cycle write and read of rob 5.
    idle(); wv = 2'b10; wpack = 2; wpay[1] = 51'h55; req = 2'b01; rob[0] = 5; cycle();
`ifdef IRAM_BYPASS_EN
    chk("t4_byp_miss", 64'(bus.rd_miss_o[0]), 64'h0);
    chk("t4_byp_pay", 64'(bus.rd_payload_o[0 +: PW]), 64'h55);
`else
    chk("t4_nobyp_miss", 64'(bus.rd_miss_o[0]), 64'h1);
`endif

    // 5: fill every pack, flush with a write to pack 0, then everything misses.
    for (int k = 0; k < DEPTH; k++) begin
      idle(); wv = 2'b11; wpack = k;
      wpay[0] = PW'(100 + 2 * k); wpay[1] = PW'(101 + 2 * k); cycle();
    end
    idle(); fl = 1'b1; wv = 2'b11; wpack = 0; wpay[0] = 51'h1; wpay[1] = 51'h2;
    req = 2'b11; rob[0] = 4; rob[1] = 31; cycle();
    chk("t5_preflush_miss", 64'(bus.rd_miss_o), 64'h0);
    for (int k = 0; k < DEPTH; k++) begin
      idle(); req = 2'b11; rob[0] = 2 * k; rob[1] = 2 * k + 1; cycle();
      chk("t5_flushed_miss", 64'(bus.rd_miss_o), 64'h3);
    end

    // 6: asynchronous reset with reads in flight.
    idle(); wv = 2'b11; wpack = 3; wpay[0] = 51'h3C; wpay[1] = 51'h3D; cycle();
    idle(); req = 2'b11; rob[0] = 6; rob[1] = 7; cycle();
    #2;
    cpu_rst_i = 1'b1;
    #1;
    model_reset();
    chk("t6_rst_valid", 64'(bus.rd_valid_o), 64'h0);
    chk("t6_rst_miss", 64'(bus.rd_miss_o), 64'h0);
    chk("t6_rst_payload", 64'(bus.rd_payload_o[63:0]), 64'h0);
    cpu_rst_i = 1'b0;
    cycle();
    chk("t6_post_miss", 64'(bus.rd_miss_o), 64'h3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      idle();
      wv    = LANES'($urandom);
      wpack = $urandom_range(0, DEPTH - 1);
      for (int l = 0; l < LANES; l++) wpay[l] = PW'({$urandom, $urandom});
      rel     = ($urandom_range(0, 7) == 0);
      relpack = $urandom_range(0, DEPTH - 1);
      fl      = ($urandom_range(0, 39) == 0);
      req     = RP'($urandom);
      for (int p = 0; p < RP; p++) rob[p] = $urandom_range(0, DEPTH * LANES - 1);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iram_mp.md
Name: iram_mp

Overview:
Parametrised instruction payload RAM for the issue path. Dispatch writes up to LANES payloads per cycle, all under one pack id; ALU issue ports read payloads by ROB index. Unlike the previous version, this block adds:
- generic lane count, depth and read-port count;
- registered reads with a valid/miss handshake;
- per-entry valid tracking, pack release and flush;
- optional same-cycle write-to-read bypass.

Parameters:
LANES, 2, dispatch lanes (payloads per pack); must be a power of two, at least 1
DEPTH, 16, number of packs; must be a power of two
PAYLOAD_W, 51, payload width ({opcode7, type5, imm_flag1, imm32, dest6})
RPORTS, 2, independent read (issue) ports
LANE_W, $clog2(LANES) (0 if LANES=1), derived
PACK_W, $clog2(DEPTH), derived
ROB_W, PACK_W+LANE_W, derived

Ports:
cpu_clk_i  in  1  clock
cpu_rst_i  in  1  asynchronous reset, active-high
wr_valid_i  in  LANES  per-lane write enable
wr_pack_i  in  PACK_W  pack id shared by all lanes this cycle
wr_payload_i  in  LANES*PAYLOAD_W  lane l occupies bits [l*PAYLOAD_W +: PAYLOAD_W]
release_i  in  1  free pack release_pack_i (clear all its lane valid bits)
release_pack_i  in  PACK_W  pack to free
flush_i  in  1  clear every valid bit
rd_req_i  in  RPORTS  per-port read request
rd_rob_i  in  RPORTS*ROB_W  per-port ROB index; lane = low LANE_W bits, pack = upper PACK_W bits
rd_valid_o  out  RPORTS  read result present (registered)
rd_miss_o  out  RPORTS  addressed entry was not valid at sample time
rd_payload_o  out  RPORTS*PAYLOAD_W  read data; zero when rd_miss_o is set

Behaviour:
Reset and storage:
- Async reset clears all valid bits, rd_valid_o, rd_miss_o and rd_payload_o to 0.
- Payload storage is not reset.

Writes:
- At posedge, for each lane l with wr_valid_i[l]: mem[l][wr_pack_i] <= payload_l and vld[l][wr_pack_i] <= 1.

Release:
- At posedge with release_i: vld[*][release_pack_i] <= 0.
- Release and write to the same pack in the same cycle: the write wins for the written lanes. Unwritten lanes of that pack are cleared.

Flush:
- flush_i clears all vld bits and overrides any same-cycle write or release; the write data is still stored but marked invalid.
- Reads sampled in the flush cycle complete normally next cycle, with rd_miss_o evaluated against pre-flush state.

Reads:
- One-cycle latency. At posedge, rd_valid_o[p] <= rd_req_i[p].
- If the entry is valid: rd_payload_o[p] <= mem, rd_miss_o[p] <= 0.
- Otherwise: rd_payload_o[p] <= 0, rd_miss_o[p] <= 1.
- With no request, rd_valid_o[p] = 0, rd_miss_o[p] = 0, and rd_payload_o holds its previous value.
- All ports are fully independent. Multiple ports may read the same entry in the same cycle.
- No back-pressure; the consumer must accept every result.

Same-cycle conflicts and lookup order:
- Read and write of the same entry in the same cycle: see IRAM_BYPASS_EN.
- Read and release of the same pack in the same cycle: the read sees the pre-release state (valid).
- Index mapping is wrap-free: pack ids and ROB indices span exactly DEPTH*LANES entries.
- For LANES=1 the lane field is absent and rob equals pack.
- Lookup order for the registered read: pre-edge state, then bypass (if enabled). Release and flush never affect the read sampled in the same cycle.

Optional Feature:
IRAM_BYPASS_EN:
- Defined: a read whose {pack, lane} matches an active wr_valid_i lane in the same cycle returns the new wr_payload_i with rd_miss_o = 0.
- Undefined: such a read returns old storage and the old valid bit. Dispatch must then keep at least one cycle between write and issue of an entry.

Decomposition:
- Package iram_pkg holds:
  - default localparams for LANES, DEPTH, PAYLOAD_W;
  - a payload struct typedef (opcode, ins_type, imm_flag, immediate, dest);
  - functions rob_lane(rob) and rob_pack(rob).
- One sub-module, iram_bank: storage plus valid bits for a single lane, with DEPTH entries, one write port, RPORTS combinational read ports, and release/flush clear.
- The top instantiates LANES banks, performs lane muxing, bypass and the output registers.

Test Plan:
1. Reset, then write lanes 0 and 1 to pack 3 (payloads 0x0A, 0x0B); next cycle read rob 6 and 7 on ports 0 and 1 -> one cycle later: valid=11, miss=00, payloads 0x0A/0x0B.
2. Read rob 9 after reset with no write -> rd_valid_o=1, rd_miss_o=1, payload 0.
3. Write pack 5, then release_i pack 5 while reading rob 10 in the same cycle -> that read hits. A read of rob 10 next cycle -> miss=1.
4. Write pack 2 lane 1 (0x55) and read rob 5 in the same cycle:
   - bypass defined -> hit, 0x55;
   - bypass undefined -> miss.
5. Fill all 16 packs, assert flush_i together with a write to pack 0 -> every subsequent read misses, including rob 0 and 1.
6. Assert cpu_rst_i asynchronously mid-stream with reads in flight -> rd_valid_o, rd_miss_o and rd_payload_o go to 0 immediately. Prior entries miss after deassert.
